// File: rtl/board_io_pkg.sv
// Shared definitions for the board I/O core: segment font, key-state encoding, PS/2 codes.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package board_io_pkg;

    // Segment byte is {dp,g,f,e,d,c,b,a}, active-low; all ones turns every segment off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // PS/2 set-2 prefix codes: break (key release) and extended-key prefix.
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        KEY_IDLE  = 2'd0,
        KEY_HELD  = 2'd1,
        KEY_BREAK = 2'd2
    } key_state_t;

    // One PS/2 frame as it arrives on the wire, first bit in the LSB.
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
        logic       start;
    } ps2_frame_t;

    // Hex glyphs 0-9, A, b, C, d, E, F with the decimal point held off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes keyboard lines, shifts in 11-bit frames, emits checked codes.
// Latency: code_valid pulses 3 clk cycles after the ps2_clk falling edge of the stop bit.
// Backpressure: none; each code is a one-cycle pulse. Option macro: PS2_PARITY_CHECK_EN.
module ps2_frame_rx
    import board_io_pkg::*;
#(
    parameter int PS2_TIMEOUT = 50_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid
);

    localparam int              TO_W     = (PS2_TIMEOUT > 1) ? $clog2(PS2_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(PS2_TIMEOUT - 1);
    localparam logic [3:0]      LAST_BIT = 4'd10;

    logic            clk_meta;
    logic            clk_sync;
    logic            clk_prev;
    logic            data_meta;
    logic            data_sync;
    logic            fall;
    logic [3:0]      bit_cnt;
    logic [9:0]      shreg;
    logic [TO_W-1:0] idle_cnt;
    ps2_frame_t      frame;
    logic            parity_ok;
    logic            frame_ok;

    // Two-flop synchronizers on both lines plus the delayed clock used for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    assign fall = clk_prev & ~clk_sync;

    // The stop bit is still on data_sync when the eleventh edge arrives; earlier bits sit in shreg.
    assign frame = {data_sync, shreg};

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^{frame.data, frame.parity};
`else
    // Parity is sampled but deliberately not checked in this build.
    logic parity_unused;
    assign parity_unused = frame.parity;
    assign parity_ok     = 1'b1;
`endif

    assign frame_ok = ~frame.start & frame.stop & parity_ok;

    // Bit collection, frame check and idle timeout that abandons a stalled partial frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            idle_cnt   <= '0;
            code       <= '0;
            code_valid <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        code       <= frame.data;
                        code_valid <= 1'b1;
                    end
                end else begin
                    shreg   <= {data_sync, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (idle_cnt == TO_LAST) begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/board_io_core.sv
// Board I/O core: switch/button/marquee LEDs, PS/2 key tracking, hex display of key and press count.
// Latency: ledr 1 cycle from sw/btn; seg 1 cycle after an accepted code (4 clk after stop-bit edge).
// Backpressure: none; inputs are sampled every cycle. Option macro: PS2_PARITY_CHECK_EN (in ps2_frame_rx).
module board_io_core
    import board_io_pkg::*;
#(
    parameter int LED_PERIOD  = 5_000_000,
    parameter int PS2_TIMEOUT = 50_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  btn,
    input  logic [7:0]  sw,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] ledr,
    output logic [7:0]  seg0,
    output logic [7:0]  seg1,
    output logic [7:0]  seg2,
    output logic [7:0]  seg3,
    output logic [7:0]  seg4,
    output logic [7:0]  seg5,
    output logic [7:0]  seg6,
    output logic [7:0]  seg7
);

    localparam int            LED_W    = (LED_PERIOD > 1) ? $clog2(LED_PERIOD) : 1;
    localparam logic [LED_W-1:0] LED_LAST = LED_W'(LED_PERIOD - 1);

    logic [LED_W-1:0] led_cnt;
    logic [7:0]       marquee;
    logic [7:0]       sw_q;
    logic [4:0]       btn_q;

    logic [7:0]       code;
    logic             code_valid;

    key_state_t       state;
    logic [7:0]       cur_code;
    logic [7:0]       press_cnt;
    logic [7:0]       cnt_inc;

    // Registered copies of the switches and buttons so every LED comes straight from a flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_q  <= '0;
            btn_q <= '0;
        end else begin
            sw_q  <= sw;
            btn_q <= btn;
        end
    end

    // Free-running marquee: one-hot rotate left once every LED_PERIOD cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_cnt <= '0;
            marquee <= 8'h01;
        end else if (led_cnt == LED_LAST) begin
            led_cnt <= '0;
            marquee <= {marquee[6:0], marquee[7]};
        end else begin
            led_cnt <= led_cnt + 1'b1;
        end
    end

    assign ledr = {marquee ^ {3'b000, btn_q}, sw_q};

    ps2_frame_rx #(
        .PS2_TIMEOUT (PS2_TIMEOUT)
    ) u_rx (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .code_valid (code_valid)
    );

    assign cnt_inc = press_cnt + 8'd1;

    // Key state machine; the digits it owns are updated on the same edge as the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= KEY_IDLE;
            cur_code  <= '0;
            press_cnt <= '0;
            seg0      <= SEG_BLANK;
            seg1      <= SEG_BLANK;
            seg4      <= hex_to_seg(4'h0);
            seg5      <= hex_to_seg(4'h0);
        end else if (code_valid) begin
            case (state)
                KEY_IDLE: begin
                    if (code == PS2_BREAK) begin
                        state <= KEY_BREAK;
                    end else if (code != PS2_EXT) begin
                        state     <= KEY_HELD;
                        cur_code  <= code;
                        press_cnt <= cnt_inc;
                        seg1      <= hex_to_seg(code[7:4]);
                        seg0      <= hex_to_seg(code[3:0]);
                        seg5      <= hex_to_seg(cnt_inc[7:4]);
                        seg4      <= hex_to_seg(cnt_inc[3:0]);
                    end
                end
                KEY_HELD: begin
                    if (code == PS2_BREAK) begin
                        state <= KEY_BREAK;
                        seg1  <= SEG_BLANK;
                        seg0  <= SEG_BLANK;
                    end else if (code != PS2_EXT && code != cur_code) begin
                        // A new key while one is held counts; typematic repeats do not.
                        cur_code  <= code;
                        press_cnt <= cnt_inc;
                        seg1      <= hex_to_seg(code[7:4]);
                        seg0      <= hex_to_seg(code[3:0]);
                        seg5      <= hex_to_seg(cnt_inc[7:4]);
                        seg4      <= hex_to_seg(cnt_inc[3:0]);
                    end
                end
                KEY_BREAK: begin
                    // The released key's code is swallowed: never latched, never counted.
                    if (code != PS2_EXT) begin
                        state <= KEY_IDLE;
                    end
                end
                default: begin
                    state <= KEY_IDLE;
                end
            endcase
        end
    end

    assign seg2 = SEG_BLANK;
    assign seg3 = SEG_BLANK;
    assign seg6 = SEG_BLANK;
    assign seg7 = SEG_BLANK;

endmodule

// File: tb/tb_board_io_core.sv
// Self-checking bench for board_io_core: LED path, PS/2 decode, key tracking and display.
// Uses a short marquee period and PS/2 timeout so every corner fits in a short run.
// Expected values come from constant tables and a behavioural key/LED model.
module tb_board_io_core;

    localparam int LP = 4;
    localparam int TO = 100;

    logic        clk      = 1'b0;
    logic        resetn   = 1'b1;
    logic [4:0]  btn      = '0;
    logic [7:0]  sw       = '0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] ledr;
    logic [7:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
    logic [63:0] seg_all;

    int total = 0;
    int bad   = 0;

    logic [7:0] font_tab [16];

    // Behavioural key model: is a key shown, are we swallowing a release code, which key, how many presses.
    logic       m_held  = 1'b0;
    logic       m_brk   = 1'b0;
    logic [7:0] m_cur   = '0;
    logic [7:0] m_cnt   = '0;

    typedef struct {
        logic [7:0] code;
        logic       held;
        logic [7:0] cur;
        logic [7:0] cnt;
    } vec_t;

    vec_t tab [16];

    always #5 clk = ~clk;

    board_io_core #(
        .LED_PERIOD  (LP),
        .PS2_TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .btn      (btn),
        .sw       (sw),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ledr     (ledr),
        .seg0     (seg0),
        .seg1     (seg1),
        .seg2     (seg2),
        .seg3     (seg3),
        .seg4     (seg4),
        .seg5     (seg5),
        .seg6     (seg6),
        .seg7     (seg7)
    );

    assign seg_all = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] font(input logic [3:0] n);
        return font_tab[n];
    endfunction

    function automatic logic [63:0] disp_of(input logic held, input logic [7:0] cur, input logic [7:0] cnt);
        return {16'hFFFF, font(cnt[7:4]), font(cnt[3:0]), 16'hFFFF,
                held ? font(cur[7:4]) : 8'hFF, held ? font(cur[3:0]) : 8'hFF};
    endfunction

    function automatic logic [63:0] exp_disp();
        return disp_of(m_held, m_cur, m_cnt);
    endfunction

    // Marquee position after n clock edges out of reset: one step per LP cycles, eight positions.
    function automatic logic [7:0] marq(input int n);
        logic [7:0] one;
        one = 8'h01;
        return one << ((n / LP) % 8);
    endfunction

    task automatic model_key(input logic [7:0] c);
        if (m_brk) begin
            if (c != 8'hE0) m_brk = 1'b0;
        end else if (c == 8'hF0) begin
            m_brk  = 1'b1;
            m_held = 1'b0;
        end else if (c != 8'hE0) begin
            if (!m_held || c != m_cur) begin
                m_cnt = m_cnt + 8'd1;
                m_cur = c;
            end
            m_held = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_held = 1'b0;
        m_brk  = 1'b0;
        m_cur  = '0;
        m_cnt  = '0;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic bad_par, input logic bad_stop);
        logic [10:0] fr;
        fr = {~bad_stop, (~^c) ^ bad_par, c, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(fr[i]);
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int n;
        logic [7:0]  c;
        logic [10:0] fr;
        logic [15:0] lexp;

        font_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                     8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

        tab[0]  = '{8'h1C, 1'b1, 8'h1C, 8'h02};
        tab[1]  = '{8'h1C, 1'b1, 8'h1C, 8'h02};
        tab[2]  = '{8'h1C, 1'b1, 8'h1C, 8'h02};
        tab[3]  = '{8'hF0, 1'b0, 8'h00, 8'h02};
        tab[4]  = '{8'h1C, 1'b0, 8'h00, 8'h02};
        tab[5]  = '{8'h32, 1'b1, 8'h32, 8'h03};
        tab[6]  = '{8'h32, 1'b1, 8'h32, 8'h03};
        tab[7]  = '{8'hE0, 1'b1, 8'h32, 8'h03};
        tab[8]  = '{8'h75, 1'b1, 8'h75, 8'h04};
        tab[9]  = '{8'hF0, 1'b0, 8'h00, 8'h04};
        tab[10] = '{8'hE0, 1'b0, 8'h00, 8'h04};
        tab[11] = '{8'h75, 1'b0, 8'h00, 8'h04};
        tab[12] = '{8'hE0, 1'b0, 8'h00, 8'h04};
        tab[13] = '{8'hF0, 1'b0, 8'h00, 8'h04};
        tab[14] = '{8'h2A, 1'b0, 8'h00, 8'h04};
        tab[15] = '{8'h2A, 1'b1, 8'h2A, 8'h05};

        // Reset state, with the first LED inputs already applied.
        sw  = 8'hA5;
        btn = 5'b00011;
        #2 resetn = 1'b0;
        #1;
        check("reset_ledr", {48'h0, ledr}, {48'h0, 16'h0100});
        check("reset_seg", seg_all, 64'hFFFF_C0C0_FFFF_FFFF);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // LED path: fixed inputs across a full marquee revolution.
        n = 0;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk);
            n++;
            #1;
            lexp = {marq(n) ^ {3'b000, btn}, sw};
            check($sformatf("led_n%0d", n), {48'h0, ledr}, {48'h0, lexp});
            if (n == 1)  check("led_first", {48'h0, ledr}, {48'h0, 16'h02A5});
            if (n == 4)  check("led_step1", {48'h0, ledr}, {48'h0, 16'h01A5});
            if (n == 32) check("led_wrap",  {48'h0, ledr}, {48'h0, 16'h02A5});
        end

        // LED path: random switches and buttons.
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            sw  = 8'($urandom_range(0, 255));
            btn = 5'($urandom_range(0, 31));
            @(posedge clk);
            n++;
            #1;
            lexp = {marq(n) ^ {3'b000, btn}, sw};
            check($sformatf("led_rand%0d", k), {48'h0, ledr}, {48'h0, lexp});
        end
        @(negedge clk);

        // Latency: display changes on the 4th clk edge after the stop-bit falling edge.
        c  = 8'h3B;
        fr = {1'b1, ~^c, c, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(fr[i]);
        ps2_data = 1'b1;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("lat_edge3", seg_all, exp_disp());
        @(posedge clk);
        #1;
        model_key(c);
        check("lat_edge4", seg_all, disp_of(1'b1, 8'h3B, 8'h01));
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);

        // Key state machine vectors.
        for (int i = 0; i < 16; i++) begin
            send_frame(tab[i].code, 1'b0, 1'b0);
            model_key(tab[i].code);
            check($sformatf("tab%0d", i), seg_all, disp_of(tab[i].held, tab[i].cur, tab[i].cnt));
        end

        // Even-parity frame: dropped only when parity checking is built in.
        send_frame(8'h1C, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        check("bad_parity", seg_all, disp_of(1'b1, 8'h2A, 8'h05));
`else
        model_key(8'h1C);
        check("bad_parity", seg_all, disp_of(1'b1, 8'h1C, 8'h06));
`endif

        // Missing stop bit: dropped silently.
        send_frame(8'h44, 1'b0, 1'b1);
        check("bad_stop", seg_all, exp_disp());

        // Partial frame abandoned after the idle timeout; next full frame decodes normally.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TO + 20) @(negedge clk);
        send_frame(8'h4B, 1'b0, 1'b0);
        model_key(8'h4B);
        check("timeout_digits", {48'h0, seg_all[15:0]}, {48'h0, font(4'h4), font(4'hB)});
        check("timeout_disp", seg_all, exp_disp());

        // Random key traffic against the model.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 7))
                0:       c = 8'hF0;
                1:       c = 8'hE0;
                2:       c = m_cur;
                default: c = 8'($urandom_range(0, 255));
            endcase
            send_frame(c, 1'b0, 1'b0);
            model_key(c);
            check($sformatf("rand%0d_%h", k, c), seg_all, exp_disp());
        end

        // Reset in the middle of a frame discards it.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        resetn   = 1'b0;
        model_reset();
        #1;
        check("midreset_seg", seg_all, 64'hFFFF_C0C0_FFFF_FFFF);
        check("midreset_ledr", {48'h0, ledr}, {48'h0, 16'h0100});
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(8'h45, 1'b0, 1'b0);
        model_key(8'h45);
        check("after_reset", seg_all, disp_of(1'b1, 8'h45, 8'h01));

        // 256 distinct presses in total: the count wraps back to 00.
        for (int k = 1; k <= 255; k++) begin
            c = (k % 2 == 1) ? 8'h11 : 8'h12;
            send_frame(c, 1'b0, 1'b0);
            model_key(c);
            if (k == 254) check("cnt_ff", {48'h0, seg_all[47:32]}, {48'h0, font(4'hF), font(4'hF)});
            if (k == 255) check("cnt_wrap", {48'h0, seg_all[47:32]}, {48'h0, font(4'h0), font(4'h0)});
        end
        check("wrap_disp", seg_all, exp_disp());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
